// File: rtl/int_issue_queue_if.sv
// Dispatch, common-data-bus and issue signals of the integer issue queue.
// master: dispatcher / CDB / integer unit side; slave: the queue itself.
interface int_issue_queue_if #(
    parameter int TAG_W = 6
);
    logic             dispatch_en;
    logic [3:0]       dispatch_op;
    logic [31:0]      dispatch_rs1_data;
    logic [31:0]      dispatch_rs2_data;
    logic [TAG_W-1:0] dispatch_rs1_tag;
    logic [TAG_W-1:0] dispatch_rs2_tag;
    logic             dispatch_rs1_rdy;
    logic             dispatch_rs2_rdy;
    logic [TAG_W-1:0] dispatch_rd_tag;

    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_data;

    logic             issue_rdy;
    logic             issue_valid;
    logic [3:0]       issue_op;
    logic [31:0]      issue_rs1_data;
    logic [31:0]      issue_rs2_data;
    logic [TAG_W-1:0] issue_rd_tag;

    modport master (
        output dispatch_en, dispatch_op, dispatch_rs1_data, dispatch_rs2_data,
               dispatch_rs1_tag, dispatch_rs2_tag, dispatch_rs1_rdy, dispatch_rs2_rdy,
               dispatch_rd_tag, cdb_valid, cdb_tag, cdb_data, issue_rdy,
        input  issue_valid, issue_op, issue_rs1_data, issue_rs2_data, issue_rd_tag
    );

    modport slave (
        input  dispatch_en, dispatch_op, dispatch_rs1_data, dispatch_rs2_data,
               dispatch_rs1_tag, dispatch_rs2_tag, dispatch_rs1_rdy, dispatch_rs2_rdy,
               dispatch_rd_tag, cdb_valid, cdb_tag, cdb_data, issue_rdy,
        output issue_valid, issue_op, issue_rs1_data, issue_rs2_data, issue_rd_tag
    );
endinterface

// File: rtl/int_issue_queue.sv
// Age-ordered, compacting integer issue queue with CDB wakeup.
// Slot 0 is always the oldest entry; valid entries occupy slots 0..count-1.
module int_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 6
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    output logic              o_full,
    int_issue_queue_if.slave  iq
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic             valid;
        logic [3:0]       op;
        logic [TAG_W-1:0] rd_tag;
        logic             rs1_rdy;
        logic [TAG_W-1:0] rs1_tag;
        logic [31:0]      rs1_data;
        logic             rs2_rdy;
        logic [TAG_W-1:0] rs2_tag;
        logic [31:0]      rs2_data;
    } entry_t;

    entry_t         q       [DEPTH];
    entry_t         woken   [DEPTH];
    entry_t         next_q  [DEPTH];
    entry_t         new_entry;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_next;
    logic [CW-1:0]  base;
    logic [IW-1:0]  sel;
    logic           found;
    logic           fire;
    logic           accept;

    // Oldest ready entry wins; selection sees registered state only, so a
    // CDB broadcast becomes issuable on the following cycle.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (q[i].valid && q[i].rs1_rdy && q[i].rs2_rdy) begin
                found = 1'b1;
                sel   = IW'(i);
            end
        end
    end

    assign iq.issue_valid    = found;
    assign iq.issue_op       = found ? q[sel].op       : '0;
    assign iq.issue_rs1_data = found ? q[sel].rs1_data : '0;
    assign iq.issue_rs2_data = found ? q[sel].rs2_data : '0;
    assign iq.issue_rd_tag   = found ? q[sel].rd_tag   : '0;
    assign o_full            = (count == CW'(DEPTH));

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woken[i] = q[i];
            if (iq.cdb_valid && q[i].valid) begin
                if (!q[i].rs1_rdy && q[i].rs1_tag == iq.cdb_tag) begin
                    woken[i].rs1_rdy  = 1'b1;
                    woken[i].rs1_data = iq.cdb_data;
                end
                if (!q[i].rs2_rdy && q[i].rs2_tag == iq.cdb_tag) begin
                    woken[i].rs2_rdy  = 1'b1;
                    woken[i].rs2_data = iq.cdb_data;
                end
            end
        end
    end

    always_comb begin
        new_entry          = '0;
        new_entry.valid    = 1'b1;
        new_entry.op       = iq.dispatch_op;
        new_entry.rd_tag   = iq.dispatch_rd_tag;
        new_entry.rs1_rdy  = iq.dispatch_rs1_rdy;
        new_entry.rs1_tag  = iq.dispatch_rs1_tag;
        new_entry.rs1_data = iq.dispatch_rs1_data;
        new_entry.rs2_rdy  = iq.dispatch_rs2_rdy;
        new_entry.rs2_tag  = iq.dispatch_rs2_tag;
        new_entry.rs2_data = iq.dispatch_rs2_data;
        if (iq.cdb_valid && !iq.dispatch_rs1_rdy && iq.dispatch_rs1_tag == iq.cdb_tag) begin
            new_entry.rs1_rdy  = 1'b1;
            new_entry.rs1_data = iq.cdb_data;
        end
        if (iq.cdb_valid && !iq.dispatch_rs2_rdy && iq.dispatch_rs2_tag == iq.cdb_tag) begin
            new_entry.rs2_rdy  = 1'b1;
            new_entry.rs2_data = iq.cdb_data;
        end
    end

    // A full queue still takes a dispatch when an issue frees the oldest
    // slot on the same edge; the newcomer lands after compaction.
    always_comb begin
        fire   = found && iq.issue_rdy;
        accept = iq.dispatch_en && (!o_full || fire);
        base   = count - CW'(fire);
        for (int i = 0; i < DEPTH - 1; i++) begin
            next_q[i] = (fire && IW'(i) >= sel) ? woken[i + 1] : woken[i];
        end
        next_q[DEPTH - 1] = fire ? '0 : woken[DEPTH - 1];
        for (int i = 0; i < DEPTH; i++) begin
            if (accept && base == CW'(i)) begin
                next_q[i] = new_entry;
            end
        end
        count_next = base + CW'(accept);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
            count <= '0;
        end else if (i_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                q[i].valid <= 1'b0;
            end
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= next_q[i];
            end
            count <= count_next;
        end
    end
endmodule

// File: tb/tb_int_issue_queue.sv
// Directed bench for int_issue_queue: stimulus pushes expected issues into a
// scoreboard queue that a negedge monitor pops on every fire.
module tb_int_issue_queue;
    typedef logic [73:0] issue_t;

    logic clk;
    logic rst_n;
    logic flush;
    logic full;
    int   checks;
    int   errors;
    issue_t exp_q[$];

    int_issue_queue_if #(.TAG_W(6)) bus();

    int_issue_queue #(.DEPTH(4), .TAG_W(6)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_flush (flush),
        .o_full  (full),
        .iq      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every fire must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.issue_valid && bus.issue_rdy) begin
            issue_t got;
            issue_t exp;
            got = {bus.issue_op, bus.issue_rs1_data, bus.issue_rs2_data, bus.issue_rd_tag};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_issue: got 0x%0h expected none", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("[TB] FAIL issue_fields: got 0x%0h expected 0x%0h", got, exp);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] d1, input logic [5:0] t1,
                                 input logic r1, input logic [31:0] d2, input logic [5:0] t2,
                                 input logic r2, input logic [5:0] rd);
        bus.dispatch_en       = 1'b1;
        bus.dispatch_op       = op;
        bus.dispatch_rs1_data = d1;
        bus.dispatch_rs1_tag  = t1;
        bus.dispatch_rs1_rdy  = r1;
        bus.dispatch_rs2_data = d2;
        bus.dispatch_rs2_tag  = t2;
        bus.dispatch_rs2_rdy  = r2;
        bus.dispatch_rd_tag   = rd;
    endtask

    task automatic broadcast(input logic [5:0] tag, input logic [31:0] data);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = tag;
        bus.cdb_data  = data;
    endtask

    task automatic expectIssue(input logic [3:0] op, input logic [31:0] d1, input logic [31:0] d2,
                               input logic [5:0] rd);
        exp_q.push_back({op, d1, d2, rd});
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        bus.dispatch_en = 1'b0;
        bus.cdb_valid   = 1'b0;
        flush           = 1'b0;
    endtask

    task automatic checkIdle(input string name);
        checkOutput({name, "_valid"}, 32'(bus.issue_valid), 32'd0);
        checkOutput({name, "_full"}, 32'(full), 32'd0);
        checkOutput({name, "_fields"},
                    32'(bus.issue_op) | bus.issue_rs1_data | bus.issue_rs2_data | 32'(bus.issue_rd_tag),
                    32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        flush  = 1'b0;
        bus.dispatch_en = 1'b0;
        applyStimulus(4'd0, 32'd0, 6'd0, 1'b0, 32'd0, 6'd0, 1'b0, 6'd0);
        bus.dispatch_en = 1'b0;
        bus.cdb_valid   = 1'b0;
        bus.cdb_tag     = '0;
        bus.cdb_data    = '0;
        bus.issue_rdy   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkIdle("reset");
        rst_n = 1'b1;
        cycle();

        // Both operands ready at dispatch: issues the next cycle.
        bus.issue_rdy = 1'b1;
        applyStimulus(4'd3, 32'h10, 6'd0, 1'b1, 32'h20, 6'd0, 1'b1, 6'd5);
        expectIssue(4'd3, 32'h10, 32'h20, 6'd5);
        cycle();
        checkOutput("t1_valid", 32'(bus.issue_valid), 32'd1);
        checkOutput("t1_rd_tag", 32'(bus.issue_rd_tag), 32'd5);
        cycle();
        checkOutput("t1_gone", 32'(bus.issue_valid), 32'd0);

        // Wakeup by CDB two cycles after dispatch; no same-cycle bypass.
        applyStimulus(4'd1, 32'd0, 6'd7, 1'b0, 32'h2, 6'd0, 1'b1, 6'd8);
        cycle();
        checkOutput("t2_wait", 32'(bus.issue_valid), 32'd0);
        cycle();
        broadcast(6'd7, 32'hABCD);
        expectIssue(4'd1, 32'hABCD, 32'h2, 6'd8);
        #1;
        checkOutput("t2_no_bypass", 32'(bus.issue_valid), 32'd0);
        cycle();
        checkOutput("t2_woken", 32'(bus.issue_valid), 32'd1);
        checkOutput("t2_rs1", bus.issue_rs1_data, 32'hABCD);
        cycle();

        // Dispatch and matching broadcast on the same edge.
        applyStimulus(4'd2, 32'd0, 6'd9, 1'b0, 32'h3, 6'd0, 1'b1, 6'd10);
        broadcast(6'd9, 32'h55);
        expectIssue(4'd2, 32'h55, 32'h3, 6'd10);
        cycle();
        checkOutput("t3_valid", 32'(bus.issue_valid), 32'd1);
        checkOutput("t3_rs1", bus.issue_rs1_data, 32'h55);
        cycle();
        checkOutput("t3_gone", 32'(bus.issue_valid), 32'd0);

        // Fill, drop while full, then issue+dispatch on the same edge.
        bus.issue_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'(i + 4), 32'(i + 32'h100), 6'd0, 1'b1, 32'(i + 32'h200), 6'd0, 1'b1, 6'(20 + i));
            expectIssue(4'(i + 4), 32'(i + 32'h100), 32'(i + 32'h200), 6'(20 + i));
            cycle();
        end
        checkOutput("t4_full", 32'(full), 32'd1);
        applyStimulus(4'd12, 32'h111, 6'd0, 1'b1, 32'h222, 6'd0, 1'b1, 6'd24);
        cycle();
        checkOutput("t4_still_full", 32'(full), 32'd1);
        checkOutput("t4_oldest", 32'(bus.issue_rd_tag), 32'd20);
        bus.issue_rdy = 1'b1;
        applyStimulus(4'd13, 32'h333, 6'd0, 1'b1, 32'h444, 6'd0, 1'b1, 6'd25);
        expectIssue(4'd13, 32'h333, 32'h444, 6'd25);
        cycle();
        checkOutput("t4_full_after_swap", 32'(full), 32'd1);
        checkOutput("t4_next_oldest", 32'(bus.issue_rd_tag), 32'd21);
        cycle();
        checkOutput("t4_not_full", 32'(full), 32'd0);
        repeat (3) cycle();
        checkIdle("t4_drained");

        // Younger ready entry bypasses an older waiting one, then flush.
        bus.issue_rdy = 1'b0;
        applyStimulus(4'd6, 32'd0, 6'd12, 1'b0, 32'h1, 6'd0, 1'b1, 6'd30);
        cycle();
        applyStimulus(4'd7, 32'h5, 6'd0, 1'b1, 32'h6, 6'd0, 1'b1, 6'd31);
        cycle();
        checkOutput("t5_young_first", 32'(bus.issue_rd_tag), 32'd31);
        bus.issue_rdy = 1'b1;
        expectIssue(4'd7, 32'h5, 32'h6, 6'd31);
        cycle();
        bus.issue_rdy = 1'b0;
        checkOutput("t5_old_waits", 32'(bus.issue_valid), 32'd0);
        broadcast(6'd12, 32'h77);
        cycle();
        checkOutput("t5_shifted_tag", 32'(bus.issue_rd_tag), 32'd30);
        checkOutput("t5_shifted_rs1", bus.issue_rs1_data, 32'h77);
        checkOutput("t5_shifted_op", 32'(bus.issue_op), 32'd6);
        flush = 1'b1;
        applyStimulus(4'd8, 32'h9, 6'd0, 1'b1, 32'h9, 6'd0, 1'b1, 6'd40);
        #1;
        checkOutput("t5_preflush_valid", 32'(bus.issue_valid), 32'd1);
        cycle();
        checkIdle("t5_flushed");
        cycle();
        checkOutput("t5_flush_dropped", 32'(bus.issue_valid), 32'd0);

        // Asynchronous reset in the middle of a wakeup.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'd9, 32'd0, 6'(50 + i), 1'b0, 32'h1, 6'd0, 1'b1, 6'(41 + i));
            cycle();
        end
        broadcast(6'd50, 32'h99);
        cycle();
        checkOutput("t6_woken", 32'(bus.issue_valid), 32'd1);
        broadcast(6'd51, 32'h98);
        rst_n = 1'b0;
        #1;
        checkIdle("t6_async_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.cdb_valid = 1'b0;
        bus.issue_rdy = 1'b1;
        broadcast(6'd52, 32'h97);
        cycle();
        checkOutput("t6_no_issue_a", 32'(bus.issue_valid), 32'd0);
        cycle();
        checkOutput("t6_no_issue_b", 32'(bus.issue_valid), 32'd0);
        applyStimulus(4'd9, 32'h6, 6'd0, 1'b1, 32'h7, 6'd0, 1'b1, 6'd60);
        expectIssue(4'd9, 32'h6, 32'h7, 6'd60);
        cycle();
        checkOutput("t6_new_valid", 32'(bus.issue_valid), 32'd1);
        cycle();
        checkOutput("t6_new_gone", 32'(bus.issue_valid), 32'd0);
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
